trace_request_sequencer: RTL and testbench

- Initiator side of the data-cache request interface: accepts trace records (command + 32-bit address) over a valid/ready handshake.
- Splits each address into tag/index/byte_offset and drives them, together with the instruction and an iteration stamp, into the data cache.
- Samples the cache's hit/miss and MRU MESI result and emits the resulting L2 bus message over a second valid/ready handshake.
- Sits between the trace-file front end and the data cache.

---
 rtl/trace_request_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_trace_request_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_request_sequencer.sv
// Trace-to-data-cache request sequencer: issues one cache request per legal trace
// record, samples the cache result and forwards any resulting L2 bus message.
module trace_request_sequencer #(
  parameter int TAG_W         = 12,
  parameter int INDEX_W       = 14,
  parameter int OFFSET_W      = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trace_valid,
  output logic                trace_ready,
  input  logic [3:0]          trace_cmd,
  input  logic [31:0]         trace_addr,
  output logic [3:0]          instruction,
  output logic [INDEX_W-1:0]  index,
  output logic [TAG_W-1:0]    tag,
  output logic [OFFSET_W-1:0] byte_offset,
  output logic [31:0]         iteration,
  input  logic                hit_miss,
  input  logic [1:0]          MESI_MRU,
  output logic                l2_valid,
  input  logic                l2_ready,
  output logic [1:0]          l2_op,
  output logic [31:0]         l2_addr,
  output logic [31:0]         req_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         err_count,
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its payload stable while valid is high and ready is low.
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, RESP, EMIT} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [31:0]           addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            instruction_q, instruction_d;
  logic [INDEX_W-1:0]    index_q, index_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [OFFSET_W-1:0]   byte_offset_q, byte_offset_d;
  logic [31:0]           iteration_q, iteration_d;
  logic                  l2_valid_q, l2_valid_d;
  logic [1:0]            l2_op_q, l2_op_d;
  logic [31:0]           l2_addr_q, l2_addr_d;
  logic [31:0]           req_count_q, req_count_d;
  logic [31:0]           miss_count_q, miss_count_d;
  logic [31:0]           err_count_q, err_count_d;
  logic [1:0]            resp_op;
  logic                  cmd_legal;

  always_comb begin
    case (trace_cmd)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd9: cmd_legal = 1'b1;
      default:                             cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    instruction_d = instruction_q;
    index_d       = index_q;
    tag_d         = tag_q;
    byte_offset_d = byte_offset_q;
    iteration_d   = iteration_q;
    l2_valid_d    = l2_valid_q;
    l2_op_d       = l2_op_q;
    l2_addr_d     = l2_addr_q;
    req_count_d   = req_count_q;
    miss_count_d  = miss_count_q;
    err_count_d   = err_count_q;
    resp_op       = 2'd0;
    trace_ready   = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (trace_valid) begin
          if (cmd_legal) begin
            cmd_d   = trace_cmd;
            addr_d  = trace_addr;
            state_d = ISSUE;
          end else begin
            err_count_d = err_count_q + 32'd1;
          end
        end
      end
      ISSUE: begin
        // The only place the cache-facing outputs change: one event per request.
        instruction_d = cmd_q;
        index_d       = addr_q[OFFSET_W +: INDEX_W];
        tag_d         = addr_q[OFFSET_W + INDEX_W +: TAG_W];
        byte_offset_d = addr_q[OFFSET_W-1:0];
        iteration_d   = iteration_q + 32'd1;
        req_count_d   = req_count_q + 32'd1;
        cnt_d         = 16'd0;
        state_d       = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = RESP;
        else                      cnt_d   = cnt_q + 16'd1;
      end
      RESP: begin
        // A post-access I state on a cmd 4 hit means the line was M and got snooped out.
        if (cmd_q == 4'd0 && !hit_miss)                          resp_op = 2'd1;
        else if (cmd_q == 4'd1 && !hit_miss)                     resp_op = 2'd2;
        else if (cmd_q == 4'd4 && hit_miss && MESI_MRU == 2'd0)  resp_op = 2'd3;
        if ((cmd_q == 4'd0 || cmd_q == 4'd1) && !hit_miss)
          miss_count_d = miss_count_q + 32'd1;
        if (resp_op != 2'd0) begin
          l2_valid_d = 1'b1;
          l2_op_d    = resp_op;
          l2_addr_d  = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
          state_d    = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (l2_ready) begin
          l2_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= 4'd0;
      addr_q        <= 32'd0;
      cnt_q         <= 16'd0;
      instruction_q <= 4'hF;
      index_q       <= '0;
      tag_q         <= '0;
      byte_offset_q <= '0;
      iteration_q   <= 32'd0;
      l2_valid_q    <= 1'b0;
      l2_op_q       <= 2'd0;
      l2_addr_q     <= 32'd0;
      req_count_q   <= 32'd0;
      miss_count_q  <= 32'd0;
      err_count_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      instruction_q <= instruction_d;
      index_q       <= index_d;
      tag_q         <= tag_d;
      byte_offset_q <= byte_offset_d;
      iteration_q   <= iteration_d;
      l2_valid_q    <= l2_valid_d;
      l2_op_q       <= l2_op_d;
      l2_addr_q     <= l2_addr_d;
      req_count_q   <= req_count_d;
      miss_count_q  <= miss_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign instruction = instruction_q;
  assign index       = index_q;
  assign tag         = tag_q;
  assign byte_offset = byte_offset_q;
  assign iteration   = iteration_q;
  assign l2_valid    = l2_valid_q;
  assign l2_op       = l2_op_q;
  assign l2_addr     = l2_addr_q;
  assign req_count   = req_count_q;
  assign miss_count  = miss_count_q;
  assign err_count   = err_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_trace_request_sequencer.sv
// Bench for trace_request_sequencer: vector table, hand-written corner sequences and
// random records checked against a request-level reference model and an L2 scoreboard.
module tb_trace_request_sequencer;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic        trace_ready;
  logic [3:0]  trace_cmd = 4'd0;
  logic [31:0] trace_addr = 32'd0;
  logic [3:0]  instruction;
  logic [13:0] index;
  logic [11:0] tag;
  logic [5:0]  byte_offset;
  logic [31:0] iteration;
  logic        hit_miss = 1'b0;
  logic [1:0]  MESI_MRU = 2'd0;
  logic        l2_valid;
  logic        l2_ready = 1'b0;
  logic [1:0]  l2_op;
  logic [31:0] l2_addr;
  logic [31:0] req_count, miss_count, err_count;
  logic [2:0]  dbg_state;

  trace_request_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cmd(trace_cmd), .trace_addr(trace_addr), .instruction(instruction),
    .index(index), .tag(tag), .byte_offset(byte_offset), .iteration(iteration),
    .hit_miss(hit_miss), .MESI_MRU(MESI_MRU), .l2_valid(l2_valid), .l2_ready(l2_ready),
    .l2_op(l2_op), .l2_addr(l2_addr), .req_count(req_count), .miss_count(miss_count),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard of expected L2 messages {op, addr}
  logic [33:0] exp_q[$];

  // reference model state
  logic [31:0] m_iter, m_req, m_miss, m_err;
  logic [3:0]  m_instr;
  logic [11:0] m_tag;
  logic [13:0] m_index;
  logic [5:0]  m_off;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  mesi;
    int          lat;
    logic [1:0]  op;
    logic [11:0] tg;
    logic [13:0] ix;
    logic [5:0]  off;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] c);
    return (c == 0 || c == 1 || c == 3 || c == 4 || c == 8 || c == 9);
  endfunction

  function automatic logic [1:0] ref_op(input logic [3:0] c, input logic h, input logic [1:0] m);
    if (c == 0 && !h) return 2'd1;
    if (c == 1 && !h) return 2'd2;
    if (c == 4 && h && m == 2'd0) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_iter = 0; m_req = 0; m_miss = 0; m_err = 0;
    m_instr = 4'hF; m_tag = 0; m_index = 0; m_off = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // L2 monitor: every accepted message must match the scoreboard head
  always @(posedge clk) begin
    if (!rst && l2_valid && l2_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL l2_unexpected: got op=%0d addr=0x%08h expected none", l2_op, l2_addr);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("l2_msg_op", {30'd0, l2_op}, {30'd0, e[33:32]});
        check("l2_msg_addr", l2_addr, e[31:0]);
      end
    end
  end

  // Driver: one trace record from the IDLE cycle back to IDLE, checking every cycle.
  // The cache result is only correct during the RESP cycle, so sampling time is checked.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic h,
                      input logic [1:0] m, input int lat, input logic rst_in_emit,
                      input logic [1:0] op, input logic [11:0] tg, input logic [13:0] ix,
                      input logic [5:0] off);
    check("ready_idle", {31'd0, trace_ready}, 32'd1);
    trace_valid = 1'b1; trace_cmd = c; trace_addr = a;
    hit_miss = ~h; MESI_MRU = m ^ 2'b11; l2_ready = 1'($urandom_range(0, 1));
    tick();
    trace_valid = 1'b0;
    if (!is_legal(c)) begin
      m_err = m_err + 1;
      check("err_count", err_count, m_err);
      check("ready_after_illegal", {31'd0, trace_ready}, 32'd1);
      check("instr_held", {28'd0, instruction}, {28'd0, m_instr});
      check("req_held", req_count, m_req);
      return;
    end
    check("ready_issue", {31'd0, trace_ready}, 32'd0);
    check("instr_before_issue", {28'd0, instruction}, {28'd0, m_instr});
    tick();
    m_iter = m_iter + 1; m_req = m_req + 1;
    m_instr = c; m_tag = tg; m_index = ix; m_off = off;
    check("instruction", {28'd0, instruction}, {28'd0, m_instr});
    check("tag", {20'd0, tag}, {20'd0, m_tag});
    check("index", {18'd0, index}, {18'd0, m_index});
    check("byte_offset", {26'd0, byte_offset}, {26'd0, m_off});
    check("iteration", iteration, m_iter);
    check("req_count", req_count, m_req);
    for (int k = 0; k < S; k++) begin
      check("ready_settle", {31'd0, trace_ready}, 32'd0);
      l2_ready = 1'($urandom_range(0, 1));
      tick();
    end
    hit_miss = h; MESI_MRU = m; l2_ready = 1'($urandom_range(0, 1));
    check("l2_valid_resp", {31'd0, l2_valid}, 32'd0);
    tick();
    hit_miss = ~h; MESI_MRU = m ^ 2'b11;
    if ((c == 0 || c == 1) && !h) m_miss = m_miss + 1;
    check("miss_count", miss_count, m_miss);
    if (op == 2'd0) begin
      l2_ready = 1'b0;
      check("ready_no_emit", {31'd0, trace_ready}, 32'd1);
      check("l2_valid_none", {31'd0, l2_valid}, 32'd0);
      return;
    end
    l2_ready = 1'b0;
    if (rst_in_emit) begin
      check("l2_valid_emit", {31'd0, l2_valid}, 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check("rst_l2_valid", {31'd0, l2_valid}, 32'd0);
      check("rst_instruction", {28'd0, instruction}, 32'hF);
      check("rst_req", req_count, 32'd0);
      check("rst_miss", miss_count, 32'd0);
      check("rst_err", err_count, 32'd0);
      check("rst_iteration", iteration, 32'd0);
      check("rst_ready", {31'd0, trace_ready}, 32'd1);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      check("l2_valid_wait", {31'd0, l2_valid}, 32'd1);
      check("l2_op_stable", {30'd0, l2_op}, {30'd0, op});
      check("l2_addr_stable", l2_addr, {tg, ix, 6'd0});
      check("ready_emit", {31'd0, trace_ready}, 32'd0);
      tick();
    end
    check("l2_valid_emit", {31'd0, l2_valid}, 32'd1);
    exp_q.push_back({op, tg, ix, 6'd0});
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    check("l2_valid_drop", {31'd0, l2_valid}, 32'd0);
    check("ready_after_emit", {31'd0, trace_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd0,  32'h1234_5678, 1'b0, 2'd0, 0, 2'd1, 12'h123, 14'h1159, 6'h38};
    vecs[1]  = '{4'd1,  32'h0000_0040, 1'b0, 2'd3, 0, 2'd2, 12'h000, 14'h0001, 6'h00};
    vecs[2]  = '{4'd1,  32'h0000_0040, 1'b1, 2'd3, 0, 2'd0, 12'h000, 14'h0001, 6'h00};
    vecs[3]  = '{4'd4,  32'hABCD_EF01, 1'b1, 2'd0, 5, 2'd3, 12'hABC, 14'h37BC, 6'h01};
    vecs[4]  = '{4'd5,  32'h1111_1111, 1'b0, 2'd0, 0, 2'd0, 12'h000, 14'h0000, 6'h00};
    vecs[5]  = '{4'd9,  32'h0000_0FFF, 1'b1, 2'd1, 0, 2'd0, 12'h000, 14'h003F, 6'h3F};
    vecs[6]  = '{4'd4,  32'h0010_0080, 1'b1, 2'd2, 0, 2'd0, 12'h001, 14'h0002, 6'h00};
    vecs[7]  = '{4'd4,  32'h0010_0080, 1'b0, 2'd0, 0, 2'd0, 12'h001, 14'h0002, 6'h00};
    vecs[8]  = '{4'd0,  32'h8000_0001, 1'b1, 2'd1, 0, 2'd0, 12'h800, 14'h0000, 6'h01};
    vecs[9]  = '{4'd8,  32'h0000_0000, 1'b0, 2'd0, 0, 2'd0, 12'h000, 14'h0000, 6'h00};
    vecs[10] = '{4'd3,  32'h0000_0000, 1'b0, 2'd0, 0, 2'd0, 12'h000, 14'h0000, 6'h00};
    vecs[11] = '{4'd15, 32'h2222_2222, 1'b0, 2'd0, 0, 2'd0, 12'h000, 14'h0000, 6'h00};
    vecs[12] = '{4'd0,  32'hFFFF_FFFF, 1'b0, 2'd2, 2, 2'd1, 12'hFFF, 14'h3FFF, 6'h3F};

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("reset_ready", {31'd0, trace_ready}, 32'd1);
    check("reset_instruction", {28'd0, instruction}, 32'hF);
    check("reset_iteration", iteration, 32'd0);
    check("reset_l2_valid", {31'd0, l2_valid}, 32'd0);
    check("reset_l2_op", {30'd0, l2_op}, 32'd0);
    check("reset_l2_addr", l2_addr, 32'd0);
    check("reset_counts", req_count | miss_count | err_count, 32'd0);
    check("reset_fields", {tag, index, byte_offset}, 32'd0);

    for (int i = 0; i < 13; i++)
      send(vecs[i].cmd, vecs[i].addr, vecs[i].hit, vecs[i].mesi, vecs[i].lat, 1'b0,
           vecs[i].op, vecs[i].tg, vecs[i].ix, vecs[i].off);

    // reset while an L2 message is pending, then a fresh request starts from iteration 1
    send(4'd4, 32'h5555_5540, 1'b1, 2'd0, 3, 1'b1, 2'd3, 12'h555, 14'h1555, 6'h00);
    send(4'd1, 32'h0000_0040, 1'b0, 2'd0, 0, 1'b0, 2'd2, 12'h000, 14'h0001, 6'h00);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic        h;
      logic [1:0]  m;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      h = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      if (i % 7 == 0) begin c = 4'd4; h = 1'b1; m = 2'd0; end
      send(c, a, h, m, $urandom_range(0, 3), 1'b0,
           is_legal(c) ? ref_op(c, h, m) : 2'd0,
           12'(a >> 20), 14'((a >> 6) % 16384), 6'(a % 64));
    end

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
